// File: rtl/master_spi.sv
// master_spi: mode-0 SPI master. Sends one byte per Start_i on MOSI (MSB
// first) while shifting one byte in from MISO, with optional CS hold for
// multi-byte frames.
//
// state | meaning
// IDLE  | waiting for Start_i; CS may still be held low from KeepCS_i
// SETUP | CS low, MOSI shows the MSB, SCK low for one half-period
// HIGH  | SCK high; MISO is captured when this phase ends
// LOW   | SCK low after a falling edge; MOSI shows the next bit
// HOLD  | final half-period after the last falling edge, then Done_o
module master_spi #(
  parameter int HALF_PERIOD = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start_i,
  input  logic       KeepCS_i,
  input  logic       Release_i,
  input  logic [7:0] DataToSend_i,
  output logic       CS_o,
  output logic       SCK_o,
  output logic       MOSI_o,
  input  logic       MISO_i,
  output logic [7:0] DataReceived_o,
  output logic       Busy_o,
  output logic       Done_o
);

  localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] half_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             keep_cs;
  logic             phase_end;

  // Last cycle of the current SCK half-period.
  assign phase_end = (half_cnt == CNT_LAST);

  // Sequencer: one register block so every pin (CS, SCK, MOSI) is glitch-free.
  // The shift register sends from its MSB end and fills from MISO at the LSB,
  // so after eight falling edges it holds the received byte.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state          <= IDLE;
      half_cnt       <= '0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      keep_cs        <= 1'b0;
      CS_o           <= 1'b1;
      SCK_o          <= 1'b0;
      MOSI_o         <= 1'b0;
      DataReceived_o <= '0;
      Busy_o         <= 1'b0;
      Done_o         <= 1'b0;
    end else begin
      Done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start_i) begin
            state     <= SETUP;
            half_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= DataToSend_i;
            keep_cs   <= KeepCS_i;
            CS_o      <= 1'b0;
            MOSI_o    <= DataToSend_i[7];
            Busy_o    <= 1'b1;
          end else if (Release_i && !CS_o) begin
            CS_o   <= 1'b1;
            MOSI_o <= 1'b0;
          end
        end
        SETUP, LOW: begin
          if (phase_end) begin
            state    <= HIGH;
            half_cnt <= '0;
            SCK_o    <= 1'b1;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            half_cnt  <= '0;
            SCK_o     <= 1'b0;
            shift_reg <= {shift_reg[6:0], MISO_i};
            if (bit_cnt == 3'd7) begin
              // MOSI keeps bit 0 through HOLD.
              state <= HOLD;
            end else begin
              state   <= LOW;
              bit_cnt <= bit_cnt + 3'd1;
              MOSI_o  <= shift_reg[6];
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (phase_end) begin
            state          <= IDLE;
            half_cnt       <= '0;
            Busy_o         <= 1'b0;
            Done_o         <= 1'b1;
            DataReceived_o <= shift_reg;
            if (!keep_cs) begin
              CS_o   <= 1'b1;
              MOSI_o <= 1'b0;
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
